// File: rtl/lcomp_channel_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : lcomp_channel_arbiter
// Purpose  : Time-multiplexes one shared limiter/compressor core among NCH
//            audio channels. Holds a per-channel threshold bank, picks one
//            requesting channel per cycle round-robin, drives the core's
//            sample/threshold/enable inputs and returns each core result
//            tagged with the channel it belongs to.
// Ports    : i_clk/i_reset          clock, synchronous active-high reset
//            i_req/i_data/o_ack     per-channel request, sample, grant pulse
//            i_cfg_*/o_cfg_err      threshold bank write port, reject pulse
//            o_core_*/i_core_data   shared core interface
//            o_valid/o_ch/o_data    tagged result stream
// Options  : LCOMP_ARB_PRIORITY_EN  channel 0 gets strict priority and does
//                                   not advance the round-robin pointer
// Revision : 1.0 - initial release
// ============================================================================
module lcomp_channel_arbiter #(
    parameter int NCH      = 4,
    parameter int W_TOTAL  = 16,
    parameter int CORE_LAT = 1
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic [NCH-1:0]             i_req,
    input  logic [NCH*W_TOTAL-1:0]     i_data,
    output logic [NCH-1:0]             o_ack,
    input  logic                       i_cfg_we,
    input  logic [$clog2(NCH)-1:0]     i_cfg_ch,
    input  logic [W_TOTAL-1:0]         i_cfg_pos,
    input  logic [W_TOTAL-1:0]         i_cfg_neg,
    output logic                       o_cfg_err,
    output logic                       o_core_ce,
    output logic [W_TOTAL-1:0]         o_core_data,
    output logic [W_TOTAL-1:0]         o_core_thr_pos,
    output logic [W_TOTAL-1:0]         o_core_thr_neg,
    input  logic [W_TOTAL-1:0]         i_core_data,
    output logic                       o_valid,
    output logic [$clog2(NCH)-1:0]     o_ch,
    output logic [W_TOTAL-1:0]         o_data
);

    localparam int              CW       = $clog2(NCH);
    localparam logic [CW:0]     c_NCH    = (CW+1)'(NCH);
    // Pass-through thresholds: full-scale positive and negative Q1.15
    localparam logic [W_TOTAL-1:0] c_POS_PT = {1'b0, {(W_TOTAL-1){1'b1}}};
    localparam logic [W_TOTAL-1:0] c_NEG_PT = {1'b1, {(W_TOTAL-1){1'b0}}};

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [W_TOTAL-1:0] r_pos_q [NCH];
    logic [W_TOTAL-1:0] r_neg_q [NCH];
    logic [CW-1:0]      r_ptr_q;
    logic [NCH-1:0]     r_ack_q;
    logic               r_ce_q;
    logic [CW-1:0]      r_iss_ch_q;
    logic [W_TOTAL-1:0] r_core_data_q;
    logic [W_TOTAL-1:0] r_thr_pos_q;
    logic [W_TOTAL-1:0] r_thr_neg_q;
    logic               r_cfg_err_q;
    logic               r_tag_vld_q [CORE_LAT];
    logic [CW-1:0]      r_tag_ch_q  [CORE_LAT];
    logic               r_valid_q;
    logic [CW-1:0]      r_ch_q;
    logic [W_TOTAL-1:0] r_data_q;

    // ------------------------------------------------------------------
    // Combinational arbitration
    // ------------------------------------------------------------------
    logic [W_TOTAL-1:0] w_ch_data [NCH];
    logic [NCH-1:0]     w_elig;
    logic               w_found;
    logic               w_adv;
    logic [CW-1:0]      w_win;
    logic [CW:0]        w_sum;
    logic [CW:0]        w_ptr_inc;
    logic [CW-1:0]      w_ptr_d;
    logic [NCH-1:0]     w_ack_d;
    logic               w_cfg_ok;

    generate
        for (genvar g = 0; g < NCH; g++) begin : g_unpack
            assign w_ch_data[g] = i_data[g*W_TOTAL +: W_TOTAL];
        end
    endgenerate

    // A channel granted this cycle is masked so it cannot win back-to-back
    assign w_elig = i_req & ~r_ack_q;

    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_sum   = '0;
        // Scan from the farthest offset down to the pointer so the last
        // match written is the first eligible channel at/after the pointer.
        for (int i = NCH-1; i >= 0; i--) begin
            w_sum = {1'b0, r_ptr_q} + (CW+1)'(i);
            if (w_sum >= c_NCH) begin
                w_sum = w_sum - c_NCH;
            end
            if (w_elig[w_sum[CW-1:0]]) begin
                w_found = 1'b1;
                w_win   = w_sum[CW-1:0];
            end
        end
        w_adv = w_found;
`ifdef LCOMP_ARB_PRIORITY_EN
        // Channel 0 overrides the rotation and leaves the pointer alone
        if (w_elig[0]) begin
            w_win = '0;
            w_adv = 1'b0;
        end
`endif
        w_ptr_inc = {1'b0, w_win} + (CW+1)'(1);
        if (!w_adv) begin
            w_ptr_d = r_ptr_q;
        end else if (w_ptr_inc == c_NCH) begin
            w_ptr_d = '0;
        end else begin
            w_ptr_d = w_ptr_inc[CW-1:0];
        end
        w_ack_d = '0;
        if (w_found) begin
            w_ack_d[w_win] = 1'b1;
        end
    end

    assign w_cfg_ok = ($signed(i_cfg_pos) >= $signed(i_cfg_neg)) &&
                      ({1'b0, i_cfg_ch} < c_NCH);

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int c = 0; c < NCH; c++) begin
                r_pos_q[c] <= c_POS_PT;
                r_neg_q[c] <= c_NEG_PT;
            end
            for (int i = 0; i < CORE_LAT; i++) begin
                r_tag_vld_q[i] <= 1'b0;
                r_tag_ch_q[i]  <= '0;
            end
            r_ptr_q       <= '0;
            r_ack_q       <= '0;
            r_ce_q        <= 1'b0;
            r_iss_ch_q    <= '0;
            r_core_data_q <= '0;
            r_thr_pos_q   <= '0;
            r_thr_neg_q   <= '0;
            r_cfg_err_q   <= 1'b0;
            r_valid_q     <= 1'b0;
            r_ch_q        <= '0;
            r_data_q      <= '0;
        end else begin
            r_ptr_q <= w_ptr_d;
            r_ack_q <= w_ack_d;
            r_ce_q  <= w_found;
            // Bank entry is read before this edge's write lands, so a write
            // to the winning channel in the decision cycle is not seen.
            if (w_found) begin
                r_iss_ch_q    <= w_win;
                r_core_data_q <= w_ch_data[w_win];
                r_thr_pos_q   <= r_pos_q[w_win];
                r_thr_neg_q   <= r_neg_q[w_win];
            end

            r_cfg_err_q <= i_cfg_we && !w_cfg_ok;
            if (i_cfg_we && w_cfg_ok) begin
                r_pos_q[i_cfg_ch] <= i_cfg_pos;
                r_neg_q[i_cfg_ch] <= i_cfg_neg;
            end

            // Tag travels alongside the core so it exits with the result
            r_tag_vld_q[0] <= r_ce_q;
            r_tag_ch_q[0]  <= r_iss_ch_q;
            for (int i = 1; i < CORE_LAT; i++) begin
                r_tag_vld_q[i] <= r_tag_vld_q[i-1];
                r_tag_ch_q[i]  <= r_tag_ch_q[i-1];
            end

            r_valid_q <= r_tag_vld_q[CORE_LAT-1];
            if (r_tag_vld_q[CORE_LAT-1]) begin
                r_ch_q   <= r_tag_ch_q[CORE_LAT-1];
                r_data_q <= i_core_data;
            end
        end
    end

    assign o_ack          = r_ack_q;
    assign o_cfg_err      = r_cfg_err_q;
    assign o_core_ce      = r_ce_q;
    assign o_core_data    = r_core_data_q;
    assign o_core_thr_pos = r_thr_pos_q;
    assign o_core_thr_neg = r_thr_neg_q;
    assign o_valid        = r_valid_q;
    assign o_ch           = r_ch_q;
    assign o_data         = r_data_q;

endmodule
`default_nettype wire

// File: tb/tb_lcomp_channel_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_lcomp_channel_arbiter
// Purpose  : Self-checking bench for lcomp_channel_arbiter with a behavioural
//            clamp core of latency CORE_LAT=4 attached to the core port.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lcomp_channel_arbiter;

    localparam int NCH = 4;
    localparam int W   = 16;
    localparam int LAT = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NCH-1:0]    req = '0;
    logic [NCH*W-1:0]  data = '0;
    logic [NCH-1:0]    o_ack;
    logic              cfg_we = 1'b0;
    logic [1:0]        cfg_ch = '0;
    logic [W-1:0]      cfg_pos = '0;
    logic [W-1:0]      cfg_neg = '0;
    logic              o_cfg_err;
    logic              o_core_ce;
    logic [W-1:0]      o_core_data, o_core_thr_pos, o_core_thr_neg;
    logic [W-1:0]      core_res;
    logic              o_valid;
    logic [1:0]        o_ch;
    logic [W-1:0]      o_data;

    always #5 clk = ~clk;

    lcomp_channel_arbiter #(.NCH(NCH), .W_TOTAL(W), .CORE_LAT(LAT)) dut (
        .i_clk(clk), .i_reset(rst), .i_req(req), .i_data(data), .o_ack(o_ack),
        .i_cfg_we(cfg_we), .i_cfg_ch(cfg_ch), .i_cfg_pos(cfg_pos), .i_cfg_neg(cfg_neg),
        .o_cfg_err(o_cfg_err), .o_core_ce(o_core_ce), .o_core_data(o_core_data),
        .o_core_thr_pos(o_core_thr_pos), .o_core_thr_neg(o_core_thr_neg),
        .i_core_data(core_res), .o_valid(o_valid), .o_ch(o_ch), .o_data(o_data)
    );

    function automatic logic [W-1:0] clamp(input logic [W-1:0] d, input logic [W-1:0] p,
                                           input logic [W-1:0] n);
        if ($signed(d) > $signed(p)) return p;
        if ($signed(d) < $signed(n)) return n;
        return d;
    endfunction

    // Behavioural shared core: clamp, LAT cycles from o_core_ce to result
    logic [W-1:0] core_pipe [LAT];
    always @(posedge clk) begin
        core_pipe[0] <= o_core_ce ? clamp(o_core_data, o_core_thr_pos, o_core_thr_neg) : '0;
        for (int i = 1; i < LAT; i++) core_pipe[i] <= core_pipe[i-1];
    end
    assign core_res = core_pipe[LAT-1];

    // ------------------------------------------------------------------
    // Scoreboard and bench-side threshold model
    // ------------------------------------------------------------------
    typedef struct { int ch; logic [W-1:0] res; int cyc; } exp_t;
    exp_t q[$];

    logic [W-1:0] m_pos [NCH];
    logic [W-1:0] m_neg [NCH];

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;
    logic got_ack, got_res;
    int ack_ch, res_ch;
    logic [W-1:0] ack_pos, ack_neg, res_data;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock: sample inputs as seen by the edge, then check what the DUT
    // shows #1 after it against the bench model.
    task automatic step();
        logic [W-1:0] sp [NCH];
        logic [W-1:0] sn [NCH];
        logic [W-1:0] sd [NCH];
        logic was_rst, was_we, ok;
        logic [1:0] wch;
        logic [W-1:0] wpos, wneg;
        exp_t e;
        sp = m_pos;
        sn = m_neg;
        for (int c = 0; c < NCH; c++) sd[c] = data[c*W +: W];
        was_rst = rst; was_we = cfg_we; wch = cfg_ch; wpos = cfg_pos; wneg = cfg_neg;
        @(posedge clk);
        #1;
        cyc++;
        got_ack = 1'b0;
        got_res = 1'b0;
        if (was_rst) begin
            q.delete();
            for (int c = 0; c < NCH; c++) begin m_pos[c] = 16'h7FFF; m_neg[c] = 16'h8000; end
            chk("rst_ack", o_ack, 0);
            chk("rst_valid", o_valid, 0);
            chk("rst_ce", o_core_ce, 0);
            return;
        end
        if (was_we) begin
            ok = $signed(wpos) >= $signed(wneg);
            chk("cfg_err", o_cfg_err, !ok);
            if (ok) begin m_pos[wch] = wpos; m_neg[wch] = wneg; end
        end else begin
            chk("cfg_err_idle", o_cfg_err, 0);
        end
        if (o_ack != '0) begin
            chk("ack_onehot", $onehot(o_ack), 1);
            chk("ack_ce", o_core_ce, 1);
            for (int c = 0; c < NCH; c++) if (o_ack[c]) ack_ch = c;
            chk("core_data", o_core_data, sd[ack_ch]);
            chk("core_thr_pos", o_core_thr_pos, sp[ack_ch]);
            chk("core_thr_neg", o_core_thr_neg, sn[ack_ch]);
            got_ack = 1'b1;
            ack_pos = o_core_thr_pos;
            ack_neg = o_core_thr_neg;
            e.ch = ack_ch; e.res = clamp(sd[ack_ch], sp[ack_ch], sn[ack_ch]); e.cyc = cyc;
            q.push_back(e);
        end else begin
            chk("idle_ce", o_core_ce, 0);
        end
        if (o_valid) begin
            got_res = 1'b1;
            res_ch = int'(o_ch);
            res_data = o_data;
            if (q.size() == 0) begin
                chk("unexpected_valid", 1, 0);
            end else begin
                e = q.pop_front();
                chk("res_ch", o_ch, e.ch);
                chk("res_data", o_data, e.res);
                chk("res_latency", cyc - e.cyc, LAT + 1);
            end
        end
    endtask

    task automatic drain(input int n);
        req = '0;
        for (int k = 0; k < n; k++) step();
    endtask

    // Table of single-channel transactions (cumulative bank effects)
    typedef struct {
        logic we; logic [1:0] cch; logic [W-1:0] pos, neg;
        int ch; logic [W-1:0] d;
        logic err; logic [W-1:0] epos, eneg, eout;
    } vec_t;
    vec_t vt [7];

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic found;
        int   exp_ch, got_ch;

        vt[0] = '{1'b0, 2'd0, 16'h0000, 16'h0000, 2, 16'h7000, 1'b0, 16'h7FFF, 16'h8000, 16'h7000};
        vt[1] = '{1'b1, 2'd1, 16'h4000, 16'hC000, 1, 16'h6000, 1'b0, 16'h4000, 16'hC000, 16'h4000};
        vt[2] = '{1'b1, 2'd0, 16'hF000, 16'h1000, 0, 16'h1234, 1'b1, 16'h7FFF, 16'h8000, 16'h1234};
        vt[3] = '{1'b1, 2'd3, 16'h1000, 16'hF000, 3, 16'h8000, 1'b0, 16'h1000, 16'hF000, 16'hF000};
        vt[4] = '{1'b1, 2'd2, 16'h0100, 16'h0100, 2, 16'h0000, 1'b0, 16'h0100, 16'h0100, 16'h0100};
        vt[5] = '{1'b1, 2'd0, 16'h0000, 16'h0001, 0, 16'h9000, 1'b1, 16'h7FFF, 16'h8000, 16'h9000};
        vt[6] = '{1'b0, 2'd0, 16'h0000, 16'h0000, 1, 16'h2000, 1'b0, 16'h4000, 16'hC000, 16'h2000};

        // Reset state
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        chk("reset_ack", o_ack, 0);
        chk("reset_cfg_err", o_cfg_err, 0);
        chk("reset_ce", o_core_ce, 0);
        chk("reset_core_data", o_core_data, 0);
        chk("reset_thr_pos", o_core_thr_pos, 0);
        chk("reset_thr_neg", o_core_thr_neg, 0);
        chk("reset_valid", o_valid, 0);
        chk("reset_ch", o_ch, 0);
        chk("reset_data", o_data, 0);

        // Table-driven single-channel transactions
        for (int v = 0; v < 7; v++) begin
            if (vt[v].we) begin
                cfg_we = 1'b1; cfg_ch = vt[v].cch; cfg_pos = vt[v].pos; cfg_neg = vt[v].neg;
                step();
                chk("tbl_cfg_err", o_cfg_err, vt[v].err);
                cfg_we = 1'b0;
                step();
                chk("tbl_cfg_err_pulse", o_cfg_err, 0);
            end
            req[vt[v].ch] = 1'b1;
            data[vt[v].ch*W +: W] = vt[v].d;
            found = 1'b0;
            for (int k = 0; k < 8 && !found; k++) begin
                step();
                if (got_ack) found = 1'b1;
            end
            req = '0;
            chk("tbl_ack_seen", found, 1);
            if (found) begin
                chk("tbl_ack_ch", ack_ch, vt[v].ch);
                chk("tbl_thr_pos", ack_pos, vt[v].epos);
                chk("tbl_thr_neg", ack_neg, vt[v].eneg);
            end
            found = 1'b0;
            for (int k = 0; k < LAT + 4 && !found; k++) begin
                step();
                if (got_res) found = 1'b1;
            end
            chk("tbl_res_seen", found, 1);
            if (found) begin
                chk("tbl_res_ch", res_ch, vt[v].ch);
                chk("tbl_res_data", res_data, vt[v].eout);
            end
            step(); step();
        end

        // Fairness: all channels requesting from a fresh pointer
        rst = 1'b1; step(); rst = 1'b0;
        for (int c = 0; c < NCH; c++) data[c*W +: W] = 16'((c + 1) << 8);
        req = '1;
        for (int k = 0; k < 12; k++) begin
            step();
`ifdef LCOMP_ARB_PRIORITY_EN
            exp_ch = (k % 2 == 0) ? 0 : ((k / 2) % 3) + 1;
`else
            exp_ch = k % NCH;
`endif
            got_ch = got_ack ? ack_ch : 255;
            chk("fair_grant", got_ch, exp_ch);
        end
        drain(12);

        // Lone requester: granted every other cycle
        req[2] = 1'b1;
        data[2*W +: W] = 16'h0555;
        for (int k = 0; k < 6; k++) begin
            step();
            chk("lone_ack", got_ack, (k % 2) == 0);
        end
        drain(12);

        // Same-cycle decision and threshold write on channel 3
        req[3] = 1'b1;
        data[3*W +: W] = 16'h7000;
        cfg_we = 1'b1; cfg_ch = 2'd3; cfg_pos = 16'h2000; cfg_neg = 16'h8000;
        step();
        cfg_we = 1'b0;
        req = '0;
        chk("same_ack", got_ack, 1);
        chk("same_old_pos", ack_pos, 16'h7FFF);
        step();
        req[3] = 1'b1;
        step();
        req = '0;
        chk("next_ack", got_ack, 1);
        chk("next_new_pos", ack_pos, 16'h2000);
        drain(12);

        // Reset two cycles after o_core_ce with an op in flight
        cfg_we = 1'b1; cfg_ch = 2'd1; cfg_pos = 16'h4000; cfg_neg = 16'hC000;
        step();
        cfg_we = 1'b0;
        req[1] = 1'b1;
        data[1*W +: W] = 16'h6000;
        step();
        req = '0;
        chk("mid_ack", got_ack, 1);
        step(); step();
        rst = 1'b1; step(); rst = 1'b0;
        for (int k = 0; k < LAT + 4; k++) begin
            step();
            chk("mid_no_valid", o_valid, 0);
        end
        req = '1;
        step();
        chk("post_rst_ack", got_ack, 1);
        chk("post_rst_ptr_ch0", ack_ch, 0);
        step();
        chk("post_rst_ack1", got_ack ? ack_ch : 255, 1);
        chk("post_rst_thr_pos", ack_pos, 16'h7FFF);
        chk("post_rst_thr_neg", ack_neg, 16'h8000);
        drain(14);

        chk("sb_empty", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
`default_nettype wire
